// File: rtl/conv11_output_ctrl.sv
// rtl/conv11_output_ctrl.sv - buffers conv11 compute words and streams exactly NUM_OUT of them per start
module conv11_output_ctrl #(
  parameter int DATA_W     = 16,
  parameter int NUM_OUT    = 64,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              done,
  output logic              busy,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              valid_out,
  output logic [DATA_W-1:0] data_out,
  input  logic              ready_in
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

  state_t            state_q, state_d;
  logic [AW:0]       wr_ptr_q, wr_ptr_d;
  logic [AW:0]       rd_ptr_q, rd_ptr_d;
  logic [15:0]       in_cnt_q, in_cnt_d;
  logic [15:0]       out_cnt_q, out_cnt_d;
  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic              fifo_empty, fifo_full;
  logic              push, pop;

  // Extra pointer bit distinguishes full from empty when the indices coincide.
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  // in_ready ignores ready_in, so a full FIFO never takes a word even on a pop cycle.
  assign in_ready  = (state_q == SEND) && !fifo_full && (in_cnt_q < 16'(NUM_OUT));
  assign valid_out = (state_q == SEND) && !fifo_empty;
  assign data_out  = mem_q[rd_ptr_q[AW-1:0]];
  assign push      = in_valid && in_ready;
  assign pop       = valid_out && ready_in;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);

  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    in_cnt_d  = in_cnt_q;
    out_cnt_d = out_cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = SEND;
          wr_ptr_d  = '0;
          rd_ptr_d  = '0;
          in_cnt_d  = '0;
          out_cnt_d = '0;
        end
      end
      SEND: begin
        if (push) begin
          wr_ptr_d = wr_ptr_q + (AW+1)'(1);
          in_cnt_d = in_cnt_q + 16'd1;
        end
        if (pop) begin
          rd_ptr_d  = rd_ptr_q + (AW+1)'(1);
          out_cnt_d = out_cnt_q + 16'd1;
          if (out_cnt_q == 16'(NUM_OUT - 1)) begin
            state_d = DONE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      in_cnt_q  <= in_cnt_d;
      out_cnt_q <= out_cnt_d;
    end
  end

  // Storage carries no reset; its contents only matter while valid_out is high.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= in_data;
    end
  end

endmodule
